// File: rtl/commit_unit.sv
// Retirement back end: registers RF writes and fetch redirects, buffers committed
// stores in a FIFO drained to data memory, and counts retired instructions.
module commit_unit #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_pc_i,
  input  logic [31:0] commit_instr_i,
  input  logic [4:0]  commit_rd_addr_i,
  input  logic [31:0] commit_result_i,
  input  logic [31:0] commit_store_data_i,
  input  logic        commit_write_enable_i,
  input  logic        commit_store_to_mem_i,
  input  logic [31:0] commit_new_pc_i,
  input  logic        commit_branch_taken_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  output logic        sb_full_o,
  output logic        sb_empty_o,
  output logic [63:0] instret_o,
  output logic [1:0]  err_o
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef struct packed {
    logic      ok;
    logic      misal;
    sb_entry_t e;
  } fmt_t;

  // Align a store to its word and move the data onto the addressed byte lanes.
  function automatic fmt_t format_store(input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input logic [31:0] data);
    fmt_t r;
    r        = '0;
    r.e.addr = {addr[31:2], 2'b00};
    r.e.data = data << {addr[1:0], 3'b000};
    case (f3)
      3'b000: begin
        r.ok   = 1'b1;
        r.e.be = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        if (addr[0]) r.misal = 1'b1;
        else begin
          r.ok   = 1'b1;
          r.e.be = 4'b0011 << addr[1:0];
        end
      end
      3'b010: begin
        if (addr[1:0] != 2'b00) r.misal = 1'b1;
        else begin
          r.ok   = 1'b1;
          r.e.be = 4'b1111;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  sb_entry_t     mem_q [SB_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          redir_q, redir_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic [63:0]   instret_q, instret_d;
  logic [1:0]    err_q, err_d;

  fmt_t      st_fmt;
  sb_entry_t head_e;
  logic      st_req, push, pop, overflow, misal, full, nonempty;
  logic      unused_ok;

  assign unused_ok = ^{commit_pc_i, commit_instr_i[31:15], commit_instr_i[11:0]};

  assign full     = (count_q == FULL_CNT);
  assign nonempty = (count_q != '0);
  assign head_e   = mem_q[head_q];

  always_comb begin
    st_fmt   = format_store(commit_instr_i[14:12], commit_result_i, commit_store_data_i);
    st_req   = commit_valid_i && commit_store_to_mem_i && st_fmt.ok;
    misal    = commit_valid_i && commit_store_to_mem_i && st_fmt.misal;
    pop      = nonempty && dmem_req_ready_i;
    // A pop frees the head slot this cycle, so a full buffer can still accept.
    push     = st_req && (!full || pop);
    overflow = st_req && full && !pop;

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase

    err_d      = err_q | {misal, overflow};
    instret_d  = instret_q + 64'(commit_valid_i);
    rf_we_d    = commit_valid_i && commit_write_enable_i && (commit_rd_addr_i != 5'd0);
    rf_waddr_d = commit_rd_addr_i;
    rf_wdata_d = commit_result_i;
    redir_d    = commit_valid_i && commit_branch_taken_i;
    redir_pc_d = commit_new_pc_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      instret_q  <= '0;
      err_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      instret_q  <= instret_d;
      err_q      <= err_d;
    end
  end

  // Payload storage needs no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= st_fmt.e;
  end

  assign rf_we_o          = rf_we_q;
  assign rf_waddr_o       = rf_waddr_q;
  assign rf_wdata_o       = rf_wdata_q;
  assign redirect_valid_o = redir_q;
  assign redirect_pc_o    = redir_pc_q;
  assign flush_o          = redir_q;
  assign dmem_req_valid_o = nonempty;
  assign dmem_addr_o      = nonempty ? head_e.addr : '0;
  assign dmem_wdata_o     = nonempty ? head_e.data : '0;
  assign dmem_be_o        = nonempty ? head_e.be   : '0;
  assign sb_full_o        = full;
  assign sb_empty_o       = !nonempty;
  assign instret_o        = instret_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: table-driven commit vectors plus store scoreboard and
// hand-written overflow, stall, misalignment and reset-mid-drain sequences.
module tb_commit_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_instr = '0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_result = '0;
  logic [31:0] commit_sdata = '0;
  logic        commit_we = 1'b0;
  logic        commit_st = 1'b0;
  logic [31:0] commit_npc = '0;
  logic        commit_taken = 1'b0;
  logic        dmem_req_ready = 1'b0;

  logic        rf_we_o, redirect_valid_o, flush_o, dmem_req_valid_o, sb_full_o, sb_empty_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, redirect_pc_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [63:0] instret_o;
  logic [1:0]  err_o;

  commit_unit #(.SB_DEPTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .commit_valid_i(commit_valid), .commit_pc_i(commit_pc), .commit_instr_i(commit_instr),
    .commit_rd_addr_i(commit_rd), .commit_result_i(commit_result),
    .commit_store_data_i(commit_sdata), .commit_write_enable_i(commit_we),
    .commit_store_to_mem_i(commit_st), .commit_new_pc_i(commit_npc),
    .commit_branch_taken_i(commit_taken),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .sb_full_o(sb_full_o), .sb_empty_o(sb_empty_o), .instret_o(instret_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] sdata;
    logic        we;
    logic        st;
    logic [31:0] npc;
    logic        taken;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_push;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_t;

  sb_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] instret_exp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                 input logic p, input logic [31:0] ea, input logic [31:0] ed,
                                 input logic [3:0] eb);
    vec_t v;
    v = '{1'b1, f3, 5'd0, a, d, 1'b0, 1'b1, 32'h0, 1'b0,
          1'b0, 5'd0, 32'h0, 1'b0, 32'h0, p, ea, ed, eb};
    return v;
  endfunction

  // Drive one commit for a cycle, then check the registered RF/redirect outputs.
  task automatic apply(input vec_t v);
    commit_valid = v.valid;
    commit_instr = (32'(v.f3) << 12) | 32'h23;
    commit_pc    = 32'h80;
    commit_rd    = v.rd;
    commit_result = v.result;
    commit_sdata = v.sdata;
    commit_we    = v.we;
    commit_st    = v.st;
    commit_npc   = v.npc;
    commit_taken = v.taken;
    if (v.e_push) sbq.push_back('{v.e_addr, v.e_data, v.e_be});
    if (v.valid) instret_exp++;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    commit_we = 1'b0;
    commit_st = 1'b0;
    commit_taken = 1'b0;
    chk("rf_we", 64'(rf_we_o), 64'(v.e_we));
    if (v.e_we) begin
      chk("rf_waddr", 64'(rf_waddr_o), 64'(v.e_waddr));
      chk("rf_wdata", 64'(rf_wdata_o), 64'(v.e_wdata));
    end
    chk("redirect_valid", 64'(redirect_valid_o), 64'(v.e_redir));
    chk("flush", 64'(flush_o), 64'(v.e_redir));
    if (v.e_redir) chk("redirect_pc", 64'(redirect_pc_o), 64'(v.e_rpc));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!sb_empty_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_sb_empty"}, 64'(sb_empty_o), 64'd1);
    chk({nm, "_sbq_drained"}, 64'(sbq.size()), 64'd0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_rf_we"}, 64'(rf_we_o), 64'd0);
    chk({nm, "_rf_waddr"}, 64'(rf_waddr_o), 64'd0);
    chk({nm, "_rf_wdata"}, 64'(rf_wdata_o), 64'd0);
    chk({nm, "_redirect"}, 64'(redirect_valid_o), 64'd0);
    chk({nm, "_redirect_pc"}, 64'(redirect_pc_o), 64'd0);
    chk({nm, "_flush"}, 64'(flush_o), 64'd0);
    chk({nm, "_dmem_valid"}, 64'(dmem_req_valid_o), 64'd0);
    chk({nm, "_dmem_addr"}, 64'(dmem_addr_o), 64'd0);
    chk({nm, "_dmem_wdata"}, 64'(dmem_wdata_o), 64'd0);
    chk({nm, "_dmem_be"}, 64'(dmem_be_o), 64'd0);
    chk({nm, "_sb_full"}, 64'(sb_full_o), 64'd0);
    chk({nm, "_sb_empty"}, 64'(sb_empty_o), 64'd1);
    chk({nm, "_instret"}, instret_o, 64'd0);
    chk({nm, "_err"}, 64'(err_o), 64'd0);
  endtask

  // Store scoreboard: every presented request must match the oldest expected store.
  always @(negedge clk) begin
    if (rstn && dmem_req_valid_o) begin
      if (sbq.size() == 0) chk("dmem_unexpected_req", 64'(dmem_req_valid_o), 64'd0);
      else begin
        chk("dmem_addr", 64'(dmem_addr_o), 64'(sbq[0].addr));
        chk("dmem_wdata", 64'(dmem_wdata_o), 64'(sbq[0].data));
        chk("dmem_be", 64'(dmem_be_o), 64'(sbq[0].be));
        if (dmem_req_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    tbl[0]  = '{1'b1, 3'd0, 5'd5, 32'h2A, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 5'd5, 32'h2A, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0};
    tbl[1]  = '{1'b1, 3'd0, 5'd0, 32'h55, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0};
    tbl[2]  = '{1'b1, 3'd0, 5'd1, 32'h84, 32'h0, 1'b1, 1'b0, 32'h100, 1'b1,
                1'b1, 5'd1, 32'h84, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0};
    tbl[3]  = '{1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0};
    tbl[4]  = mk_st(3'd0, 32'h1003, 32'h000000AB, 1'b1, 32'h1000, 32'hAB000000, 4'b1000);
    tbl[5]  = mk_st(3'd1, 32'h1002, 32'h00001234, 1'b1, 32'h1000, 32'h12340000, 4'b1100);
    tbl[6]  = mk_st(3'd0, 32'h1001, 32'h123456CD, 1'b1, 32'h1000, 32'h3456CD00, 4'b0010);
    tbl[7]  = mk_st(3'd2, 32'h2000, 32'hDEADBEEF, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b1111);
    tbl[8]  = mk_st(3'd1, 32'h2004, 32'h0000BEEF, 1'b1, 32'h2004, 32'h0000BEEF, 4'b0011);
    tbl[9]  = mk_st(3'd3, 32'h3000, 32'h12345678, 1'b0, 32'h0, 32'h0, 4'h0);
    tbl[10] = tbl[3];

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rstn = 1'b1;
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) apply(tbl[i]);
    drain("table");
    chk("err_after_table", 64'(err_o), 64'd0);
    chk("instret_table", instret_o, instret_exp);

    // Full buffer accepting a push in the same cycle as a pop.
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      apply(mk_st(3'd2, 32'h4000 + 32'(4 * i), 32'h11 * 32'(i + 1), 1'b1,
                  32'h4000 + 32'(4 * i), 32'h11 * 32'(i + 1), 4'b1111));
    chk("pp_full_before", 64'(sb_full_o), 64'd1);
    dmem_req_ready = 1'b1;
    apply(mk_st(3'd2, 32'h4010, 32'h55, 1'b1, 32'h4010, 32'h55, 4'b1111));
    chk("pp_full_after", 64'(sb_full_o), 64'd1);
    chk("pp_no_overflow", 64'(err_o), 64'd0);
    drain("pushpop");

    // Overflow with ready held low; payload is rechecked every stalled cycle.
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(mk_st(3'd2, 32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), (i < 4) ? 1'b1 : 1'b0,
                  32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111));
      if (i == 3) begin
        chk("ovf_full_4th", 64'(sb_full_o), 64'd1);
        chk("ovf_err_before", 64'(err_o), 64'd0);
      end
    end
    chk("ovf_err_5th", 64'(err_o), 64'd1);
    chk("ovf_full_5th", 64'(sb_full_o), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    dmem_req_ready = 1'b1;
    drain("overflow");
    chk("ovf_err_sticky", 64'(err_o), 64'd1);

    // Misaligned stores are dropped and flagged.
    apply(mk_st(3'd2, 32'h1001, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 4'h0));
    chk("misal_err", 64'(err_o), 64'd3);
    apply(mk_st(3'd1, 32'h1003, 32'h0000F00D, 1'b0, 32'h0, 32'h0, 4'h0));
    @(posedge clk);
    #1;
    chk("misal_empty", 64'(sb_empty_o), 64'd1);

    // Ten commits from a clean reset, then asynchronous reset while draining.
    rstn = 1'b0;
    sbq.delete();
    instret_exp = '0;
    #2;
    rstn = 1'b1;
    dmem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i < 3)
        apply(mk_st(3'd2, 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 1'b1,
                    32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 4'b1111));
      else
        apply('{1'b1, 3'd0, 5'd7, 32'(i), 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 5'd7, 32'(i), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0});
    end
    chk("instret_ten", instret_o, 64'd10);
    chk("instret_ten_model", instret_o, instret_exp);
    chk("mid_valid_before_rst", 64'(dmem_req_valid_o), 64'd1);
    dmem_req_ready = 1'b1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    sbq.delete();
    #1;
    chk_reset_state("midreset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_empty", 64'(sb_empty_o), 64'd1);
    chk("post_rst_valid", 64'(dmem_req_valid_o), 64'd0);
    chk("post_rst_instret", instret_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
